cp0_exc_unit: RTL and testbench

Coprocessor-0 exception commit unit for the MIPS pipeline. It consumes the single `exception_t` record produced at the commit point and updates the architectural CP0 registers: BadVAddr, Count, Compare, Status, Cause and EPC. It also handles ERET and raises a registered PC redirect to the fetch stage. It accumulates interrupt sources and reports a pending interrupt upstream, where the record builder injects a `CODE_INT` exception.

---
 rtl/cp0_exc_unit_if.sv | 75 +++++++
 rtl/cp0_exc_unit.sv | 214 +++++++++++++++++++++
 tb/tb_cp0_exc_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_exc_unit_if.sv
// cp0_exc_unit_if -- commit-side bundle between the pipeline and the CP0
// exception unit, plus the shared exception record type.
//
// Package cp0_exc_pkg:
//   exception_t : commit-point exception record
//                 (valid, location, pc, in_delay_slot, code, badvaddr)
//   CODE_*      : ExcCode values used by the pipeline
//   EXC_VECTOR  : general exception vector (BEV=1 space)
//
// Interface signals:
//   exc            : commit-point exception record        (master -> slave)
//   eret           : ERET committing this cycle            (master -> slave)
//   cp0_we         : MTC0 commit                           (master -> slave)
//   cp0_waddr      : MTC0 register number                  (master -> slave)
//   cp0_wdata      : MTC0 data                             (master -> slave)
//   cp0_raddr      : MFC0 register number                  (master -> slave)
//   ext_int        : HW5..HW0 interrupt lines, level       (master -> slave)
//   cp0_rdata      : MFC0 data, combinational              (slave -> master)
//   int_pending    : enabled, unmasked interrupt pending   (slave -> master)
//   status_exl     : current Status.EXL                    (slave -> master)
//   redirect_valid : one-cycle fetch restart pulse         (slave -> master)
//   redirect_pc    : fetch restart address                 (slave -> master)

package cp0_exc_pkg;

    typedef struct packed {
        logic        valid;
        logic [1:0]  location;
        logic [31:0] pc;
        logic        in_delay_slot;
        logic [4:0]  code;
        logic [31:0] badvaddr;
    } exception_t;

    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_MOD  = 5'd1;
    localparam logic [4:0] CODE_TLBL = 5'd2;
    localparam logic [4:0] CODE_TLBS = 5'd3;
    localparam logic [4:0] CODE_ADEL = 5'd4;
    localparam logic [4:0] CODE_ADES = 5'd5;
    localparam logic [4:0] CODE_SYS  = 5'd8;
    localparam logic [4:0] CODE_BP   = 5'd9;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_OV   = 5'd12;

    localparam logic [31:0] EXC_VECTOR = 32'hbfc0_0380;

endpackage

interface cp0_exc_unit_if;

    cp0_exc_pkg::exception_t exc;
    logic        eret;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [5:0]  ext_int;
    logic [31:0] cp0_rdata;
    logic        int_pending;
    logic        status_exl;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output exc, eret, cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, ext_int,
        input  cp0_rdata, int_pending, status_exl, redirect_valid, redirect_pc
    );

    modport slave (
        input  exc, eret, cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, ext_int,
        output cp0_rdata, int_pending, status_exl, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit -- Coprocessor-0 exception commit unit.
//
// Holds BadVAddr, Count, Compare, Status, Cause and EPC; commits the
// pipeline's exception record and ERET, and issues a registered one-cycle
// fetch redirect. Reports a pending, enabled interrupt upstream.
//
// Parameters:
//   COUNT_DIV : Count increments once every COUNT_DIV cycles (1 or 2).
// Configuration macro:
//   CP0_TIMER_INT_EN : when defined, Count==Compare raises Cause.TI, which is
//                      ORed into IP[7]; an MTC0 to Compare clears it. When
//                      undefined, TI stays 0.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : cp0_exc_unit_if.slave (commit record, ERET, MTC0/MFC0,
//           interrupt lines, redirect and status outputs)

module cp0_exc_unit #(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    cp0_exc_unit_if.slave    bus
);

    import cp0_exc_pkg::*;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    logic [31:0] badvaddr_q,       badvaddr_d;
    logic [31:0] count_q,          count_d;
    logic        count_phase_q,    count_phase_d;
    logic [31:0] compare_q,        compare_d;
    logic        status_bev_q,     status_bev_d;
    logic [7:0]  status_im_q,      status_im_d;
    logic        status_exl_q,     status_exl_d;
    logic        status_ie_q,      status_ie_d;
    logic        cause_bd_q,       cause_bd_d;
    logic        cause_ti_q,       cause_ti_d;
    logic [1:0]  cause_ip_sw_q,    cause_ip_sw_d;
    logic [5:0]  cause_ip_hw_q,    cause_ip_hw_d;
    logic [4:0]  cause_exccode_q,  cause_exccode_d;
    logic [31:0] epc_q,            epc_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q,    redirect_pc_d;

    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic        count_tick;
    logic [31:0] count_inc;
    logic        badvaddr_code;
    logic [7:0]  cause_ip;
    logic        unused_location;

    assign unused_location = ^bus.exc.location;

    assign wr_count   = bus.cp0_we && (bus.cp0_waddr == REG_COUNT);
    assign wr_compare = bus.cp0_we && (bus.cp0_waddr == REG_COMPARE);
    assign wr_status  = bus.cp0_we && (bus.cp0_waddr == REG_STATUS);
    assign wr_cause   = bus.cp0_we && (bus.cp0_waddr == REG_CAUSE);
    assign wr_epc     = bus.cp0_we && (bus.cp0_waddr == REG_EPC);

    // With a divide of 1 the phase bit is unused and Count ticks every cycle.
    assign count_tick = (COUNT_DIV == 1) ? 1'b1 : count_phase_q;
    assign count_inc  = count_q + 32'd1;

    assign badvaddr_code = (bus.exc.code == CODE_ADEL) || (bus.exc.code == CODE_ADES) ||
                           (bus.exc.code == CODE_TLBL) || (bus.exc.code == CODE_TLBS) ||
                           (bus.exc.code == CODE_MOD);

    // IP[7] merges the HW5 line with the timer flag (held 0 without the timer).
    assign cause_ip = {cause_ip_hw_q[5] | cause_ti_q, cause_ip_hw_q[4:0], cause_ip_sw_q};

    always_comb begin
        badvaddr_d       = badvaddr_q;
        count_d          = count_q;
        count_phase_d    = count_phase_q;
        compare_d        = compare_q;
        status_bev_d     = status_bev_q;
        status_im_d      = status_im_q;
        status_exl_d     = status_exl_q;
        status_ie_d      = status_ie_q;
        cause_bd_d       = cause_bd_q;
        cause_ti_d       = cause_ti_q;
        cause_ip_sw_d    = cause_ip_sw_q;
        cause_ip_hw_d    = bus.ext_int;
        cause_exccode_d  = cause_exccode_q;
        epc_d            = epc_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;

        // MTC0 first; an exception or ERET below overrides the fields it owns.
        if (wr_status) begin
            status_bev_d = bus.cp0_wdata[22];
            status_im_d  = bus.cp0_wdata[15:8];
            status_exl_d = bus.cp0_wdata[1];
            status_ie_d  = bus.cp0_wdata[0];
        end
        if (wr_cause) begin
            cause_ip_sw_d = bus.cp0_wdata[9:8];
        end
        if (wr_epc) begin
            epc_d = bus.cp0_wdata;
        end
        if (wr_compare) begin
            compare_d = bus.cp0_wdata;
        end

        if (wr_count) begin
            count_d       = bus.cp0_wdata;
            count_phase_d = 1'b0;
        end else begin
            if (COUNT_DIV != 1) begin
                count_phase_d = ~count_phase_q;
            end
            if (count_tick) begin
                count_d = count_inc;
            end
        end

`ifdef CP0_TIMER_INT_EN
        if (wr_compare) begin
            cause_ti_d = 1'b0;
        end else if (!wr_count && count_tick && (count_inc == compare_q)) begin
            cause_ti_d = 1'b1;
        end
`else
        cause_ti_d = 1'b0;
`endif

        if (bus.exc.valid) begin
            // A nested exception keeps the original EPC/BD.
            if (!status_exl_q) begin
                epc_d      = bus.exc.in_delay_slot ? (bus.exc.pc - 32'd4) : bus.exc.pc;
                cause_bd_d = bus.exc.in_delay_slot;
            end
            cause_exccode_d  = bus.exc.code;
            status_exl_d     = 1'b1;
            if (badvaddr_code) begin
                badvaddr_d = bus.exc.badvaddr;
            end
            redirect_valid_d = 1'b1;
            redirect_pc_d    = EXC_VECTOR;
        end else if (bus.eret) begin
            status_exl_d     = 1'b0;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = epc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            badvaddr_q       <= '0;
            count_q          <= '0;
            count_phase_q    <= 1'b0;
            compare_q        <= '0;
            status_bev_q     <= 1'b1;
            status_im_q      <= '0;
            status_exl_q     <= 1'b0;
            status_ie_q      <= 1'b0;
            cause_bd_q       <= 1'b0;
            cause_ti_q       <= 1'b0;
            cause_ip_sw_q    <= '0;
            cause_ip_hw_q    <= '0;
            cause_exccode_q  <= '0;
            epc_q            <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            badvaddr_q       <= badvaddr_d;
            count_q          <= count_d;
            count_phase_q    <= count_phase_d;
            compare_q        <= compare_d;
            status_bev_q     <= status_bev_d;
            status_im_q      <= status_im_d;
            status_exl_q     <= status_exl_d;
            status_ie_q      <= status_ie_d;
            cause_bd_q       <= cause_bd_d;
            cause_ti_q       <= cause_ti_d;
            cause_ip_sw_q    <= cause_ip_sw_d;
            cause_ip_hw_q    <= cause_ip_hw_d;
            cause_exccode_q  <= cause_exccode_d;
            epc_q            <= epc_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    always_comb begin
        bus.cp0_rdata = '0;
        unique case (bus.cp0_raddr)
            REG_BADVADDR: bus.cp0_rdata = badvaddr_q;
            REG_COUNT:    bus.cp0_rdata = count_q;
            REG_COMPARE:  bus.cp0_rdata = compare_q;
            REG_STATUS:   bus.cp0_rdata = {9'b0, status_bev_q, 6'b0, status_im_q,
                                           6'b0, status_exl_q, status_ie_q};
            REG_CAUSE:    bus.cp0_rdata = {cause_bd_q, cause_ti_q, 14'b0, cause_ip,
                                           1'b0, cause_exccode_q, 2'b0};
            REG_EPC:      bus.cp0_rdata = epc_q;
            default:      bus.cp0_rdata = '0;
        endcase
    end

    assign bus.int_pending    = status_ie_q & ~status_exl_q & (|(cause_ip & status_im_q));
    assign bus.status_exl     = status_exl_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb_cp0_exc_unit -- scoreboard bench for cp0_exc_unit.
// Stimulus (directed then random) is applied each falling edge; a reference
// model of the CP0 register file predicts the observable outputs and pushes
// them into queues that a separate monitor pops and compares.

module tb_cp0_exc_unit;

    import cp0_exc_pkg::*;

`ifdef CP0_TIMER_INT_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif
    localparam int CDIV = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cp0_exc_unit_if bus ();

    cp0_exc_unit #(.COUNT_DIV(CDIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  raddr;
        logic [31:0] rdata;
        logic        ip;
        logic        exl;
        logic        rv;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] redir_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    // drive values for the next step
    exception_t  d_exc;
    logic        d_eret;
    logic        d_we;
    logic [4:0]  d_waddr;
    logic [31:0] d_wdata;
    logic [4:0]  d_raddr;
    logic [5:0]  d_ext;

    // reference model state
    logic [31:0] m_status, m_epc, m_badv, m_count, m_compare, m_rpc;
    logic        m_bd, m_ti, m_rv;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_hw;
    logic [4:0]  m_code;
    int          m_div;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] m_ip();
        return {m_hw[5] | (TIMER & m_ti), m_hw[4:0], m_ipsw};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return {m_bd, TIMER & m_ti, 14'b0, m_ip(), 1'b0, m_code, 2'b0};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_status = 32'h0040_0000; m_epc = '0; m_badv = '0; m_count = '0;
        m_compare = '0; m_rpc = '0; m_bd = 0; m_ti = 0; m_rv = 0;
        m_ipsw = '0; m_hw = '0; m_code = '0; m_div = 0;
    endtask

    // Drive the current inputs (called at a falling edge), predict what the
    // monitor will see this cycle, advance the model across the next rising
    // edge, then wait for the following falling edge.
    task automatic step();
        exp_t        e;
        logic        old_exl;
        logic [31:0] old_epc;
        logic        cmp_wr;
        bus.exc       = d_exc;
        bus.eret      = d_eret;
        bus.cp0_we    = d_we;
        bus.cp0_waddr = d_waddr;
        bus.cp0_wdata = d_wdata;
        bus.cp0_raddr = d_raddr;
        bus.ext_int   = d_ext;

        e.raddr = d_raddr;
        e.rdata = m_read(d_raddr);
        e.ip    = m_status[0] & ~m_status[1] & (|(m_ip() & m_status[15:8]));
        e.exl   = m_status[1];
        e.rv    = m_rv;
        exp_q.push_back(e);

        old_exl = m_status[1];
        old_epc = m_epc;
        cmp_wr  = d_we && d_waddr == 5'd11;

        if (d_we && d_waddr == 5'd9) begin
            m_count = d_wdata;
            m_div   = 0;
        end else begin
            m_div++;
            if (m_div == CDIV) begin
                m_div   = 0;
                m_count = m_count + 1;
                if (TIMER && !cmp_wr && m_count == m_compare) m_ti = 1'b1;
            end
        end
        if (cmp_wr) begin
            m_compare = d_wdata;
            m_ti      = 1'b0;
        end
        if (d_we && d_waddr == 5'd12) m_status = d_wdata & 32'h0040_ff03;
        if (d_we && d_waddr == 5'd13) m_ipsw = d_wdata[9:8];
        if (d_we && d_waddr == 5'd14) m_epc = d_wdata;

        if (d_exc.valid) begin
            if (!old_exl) begin
                m_epc = d_exc.in_delay_slot ? d_exc.pc - 4 : d_exc.pc;
                m_bd  = d_exc.in_delay_slot;
            end
            m_code = d_exc.code;
            m_status[1] = 1'b1;
            if (d_exc.code inside {CODE_ADEL, CODE_ADES, CODE_TLBL, CODE_TLBS, CODE_MOD})
                m_badv = d_exc.badvaddr;
            m_rv  = 1'b1;
            m_rpc = 32'hbfc0_0380;
            redir_q.push_back(m_rpc);
        end else if (d_eret) begin
            m_status[1] = 1'b0;
            m_rv  = 1'b1;
            m_rpc = old_epc;
            redir_q.push_back(m_rpc);
        end else begin
            m_rv = 1'b0;
        end
        m_hw = d_ext;

        d_exc.valid = 1'b0;
        d_eret      = 1'b0;
        d_we        = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] ra);
        d_raddr = ra;
        step();
    endtask

    task automatic mtc0(input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] ra);
        d_we = 1'b1; d_waddr = wa; d_wdata = wd; d_raddr = ra;
        step();
    endtask

    task automatic commit(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                          input logic [31:0] badv, input logic also_eret);
        d_exc.valid = 1'b1; d_exc.code = code; d_exc.pc = pc;
        d_exc.in_delay_slot = ds; d_exc.badvaddr = badv;
        d_exc.location = 2'($urandom_range(3));
        d_eret = also_eret;
        step();
    endtask

    task automatic do_eret(input logic [4:0] ra);
        d_eret = 1'b1; d_raddr = ra;
        step();
    endtask

    // monitor: compares every cycle while enabled; pops a redirect target
    // whenever the DUT pulses redirect_valid
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    check("exp_queue_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rdata[%0d]", e.raddr), bus.cp0_rdata, e.rdata);
                    check("int_pending", {31'b0, bus.int_pending}, {31'b0, e.ip});
                    check("status_exl", {31'b0, bus.status_exl}, {31'b0, e.exl});
                    check("redirect_valid", {31'b0, bus.redirect_valid}, {31'b0, e.rv});
                end
                if (bus.redirect_valid === 1'b1) begin
                    if (redir_q.size() == 0) check("unexpected_redirect", 32'd1, 32'd0);
                    else check("redirect_pc", bus.redirect_pc, redir_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [4:0]  rst_addr[6];
        logic [31:0] rst_val[6];
        logic [4:0]  codes[10];
        logic [4:0]  waddrs[7];
        rst_addr = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
        rst_val  = '{32'h0, 32'h0, 32'h0, 32'h0040_0000, 32'h0, 32'h0};
        codes    = '{CODE_INT, CODE_MOD, CODE_TLBL, CODE_TLBS, CODE_ADEL,
                     CODE_ADES, CODE_SYS, CODE_BP, CODE_RI, CODE_OV};
        waddrs   = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};

        d_exc = '0; d_eret = 0; d_we = 0; d_waddr = '0; d_wdata = '0; d_raddr = '0; d_ext = '0;
        bus.exc = '0; bus.eret = 0; bus.cp0_we = 0; bus.cp0_waddr = '0;
        bus.cp0_wdata = '0; bus.cp0_raddr = '0; bus.ext_int = '0;
        model_reset();

        // reset values
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            bus.cp0_raddr = rst_addr[i];
            #1;
            check($sformatf("reset_rdata[%0d]", rst_addr[i]), bus.cp0_rdata, rst_val[i]);
        end
        check("reset_redirect_valid", {31'b0, bus.redirect_valid}, 32'd0);
        check("reset_redirect_pc", bus.redirect_pc, 32'd0);
        check("reset_int_pending", {31'b0, bus.int_pending}, 32'd0);
        check("reset_status_exl", {31'b0, bus.status_exl}, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        // idle: Count ticks every second cycle
        repeat (11) idle(5'd9);
        idle(5'd12);

        // exception in a delay slot, then readback
        commit(CODE_ADEL, 32'hbfc0_1004, 1'b1, 32'h0000_0003, 1'b0);
        idle(5'd14); idle(5'd13); idle(5'd8); idle(5'd12);

        // nested exception keeps EPC, then ERET to saved EPC
        commit(CODE_SYS, 32'h8000_1234, 1'b0, 32'hdead_beef, 1'b0);
        idle(5'd14); idle(5'd13); idle(5'd8);
        do_eret(5'd12);
        idle(5'd12);

        // exception and ERET together: exception wins
        commit(CODE_RI, 32'h8000_2000, 1'b0, 32'h0, 1'b1);
        idle(5'd12);
        do_eret(5'd12);
        idle(5'd14);

        // back-to-back events
        commit(CODE_BP, 32'h8000_3000, 1'b0, 32'h0, 1'b0);
        do_eret(5'd14);
        idle(5'd12);

        // external interrupt: IM2 + IE, then an exception masks it via EXL
        mtc0(5'd12, 32'h0000_8401, 5'd12);
        d_ext = 6'b000001;
        idle(5'd13); idle(5'd13); idle(5'd13);
        commit(CODE_OV, 32'h8000_4000, 1'b0, 32'h0, 1'b0);
        idle(5'd13); idle(5'd13);
        do_eret(5'd12);
        d_ext = 6'b0;
        idle(5'd13); idle(5'd13);

        // timer: Compare=3, Count=0, IM7 + IE
        mtc0(5'd12, 32'h0000_8001, 5'd12);
        mtc0(5'd11, 32'd3, 5'd11);
        mtc0(5'd9, 32'd0, 5'd9);
        repeat (8) idle(5'd13);
        mtc0(5'd11, 32'd100, 5'd13);
        idle(5'd13); idle(5'd9);

        // Count wrap
        mtc0(5'd9, 32'hffff_fffe, 5'd9);
        repeat (6) idle(5'd9);

        // MTC0 to EPC in the same cycle as ERET uses old EPC
        d_we = 1'b1; d_waddr = 5'd14; d_wdata = 32'h1234_5678;
        do_eret(5'd14);
        idle(5'd14);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) begin
                d_exc.valid = 1'b1;
                d_exc.code = codes[$urandom_range(9)];
            end else begin
                d_exc.valid = 1'b0;
                d_exc.code = 5'($urandom);
            end
            d_exc.pc = $urandom & 32'hffff_fffc;
            d_exc.in_delay_slot = 1'($urandom);
            d_exc.badvaddr = $urandom;
            d_exc.location = 2'($urandom);
            d_eret = ($urandom_range(6) == 0);
            d_we = ($urandom_range(3) == 0);
            d_waddr = waddrs[$urandom_range(6)];
            if (d_waddr == 5'd0) d_waddr = 5'($urandom);
            d_wdata = $urandom;
            if (d_waddr == 5'd9 && $urandom_range(1) == 0) d_wdata = m_compare - $urandom_range(6);
            if (d_waddr == 5'd12 && $urandom_range(1) == 0) d_wdata = d_wdata & 32'hffff_fffd;
            if ($urandom_range(7) == 0) d_ext = 6'($urandom);
            d_raddr = ($urandom_range(3) == 0) ? 5'($urandom) : waddrs[$urandom_range(5)];
            step();
        end
        d_exc.valid = 1'b0;
        repeat (3) idle(5'd12);
        mon_en = 1'b0;
        check("redirects_outstanding", redir_q.size(), 32'd0);

        // async reset during a redirect pulse
        d_exc.valid = 1'b1; d_exc.code = CODE_SYS;
        bus.exc = d_exc;
        @(posedge clk);
        #1;
        bus.exc.valid = 1'b0;
        check("pulse_before_reset", {31'b0, bus.redirect_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("redirect_valid_async_reset", {31'b0, bus.redirect_valid}, 32'd0);
        check("redirect_pc_async_reset", bus.redirect_pc, 32'd0);
        check("status_exl_async_reset", {31'b0, bus.status_exl}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
